// File: rtl/tmr_cfg_write_verify_pkg.sv
// tmr_cfg_write_verify_pkg: shared state encoding, reset constants and sizing helper
package tmr_cfg_write_verify_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, SETTLE, CHECK} state_t;

   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_PULSE = 1'b0;

   function automatic int retry_w(input int max_retry);
      return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   endfunction

endpackage

// File: rtl/tmr_cfg_write_verify_sat_counter.sv
// tmr_sat_counter: saturating up-counter with synchronous clear that beats increment
module tmr_sat_counter #(
   parameter int W = 8
) (
   input  logic         CP,
   input  logic         CDN,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge CP or negedge CDN)
      if (!CDN) cnt_q <= '0;
      else      cnt_q <= cnt_d;

   assign cnt = cnt_q;

endmodule

// File: rtl/tmr_cfg_write_verify.sv
// tmr_cfg_write_verify: writes one row of the TMR config bank, reads back the voted
// value and rewrites on mismatch up to MAX_RETRY times, counting failed compares.
module tmr_cfg_write_verify
   import tmr_cfg_write_verify_pkg::*;
#(
   parameter int NREG      = 16,
   parameter int DW        = 16,
   parameter int AW        = 4,
   parameter int MAX_RETRY = 2,
   parameter int ERRW      = 8
) (
   input  logic               CP,
   input  logic               CDN,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DW-1:0]      wr_data,
   output logic [NREG-1:0]    reg_en,
   output logic [DW-1:0]      reg_d,
   input  logic [NREG*DW-1:0] reg_q,
   output logic               done_pulse,
   output logic               fail_pulse,
   output logic [ERRW-1:0]    err_cnt,
   input  logic               err_clr
);

   localparam int RW = retry_w(MAX_RETRY);

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [NREG-1:0] reg_en_q, reg_en_d;
   logic            done_q, done_d;
   logic            fail_q, fail_d;
   logic            inc;
   logic [DW-1:0]   row_q;

   assign row_q = reg_q[int'(addr_q)*DW +: DW];

   // reg_en is registered so the row enable is a clean single-cycle pulse in WRITE
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      retry_d  = retry_q;
      reg_en_d = '0;
      done_d   = RST_PULSE;
      fail_d   = RST_PULSE;
      inc      = 1'b0;
      case (state_q)
         IDLE: if (wr_valid) begin
            addr_d  = wr_addr;
            data_d  = wr_data;
            retry_d = '0;
            if (int'(wr_addr) < NREG) begin
               state_d  = WRITE;
               reg_en_d = NREG'(1) << wr_addr;
            end else begin
               fail_d = 1'b1;
            end
         end
         WRITE:  state_d = SETTLE;
         SETTLE: state_d = CHECK;
         CHECK: if (row_q == data_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            inc = 1'b1;
            if (retry_q == RW'(MAX_RETRY)) begin
               state_d = IDLE;
               fail_d  = 1'b1;
            end else begin
               retry_d  = retry_q + 1'b1;
               state_d  = WRITE;
               reg_en_d = NREG'(1) << addr_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CP or negedge CDN) begin
      if (!CDN) begin
         state_q  <= RST_STATE;
         addr_q   <= '0;
         data_q   <= '0;
         retry_q  <= '0;
         reg_en_q <= '0;
         done_q   <= RST_PULSE;
         fail_q   <= RST_PULSE;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         retry_q  <= retry_d;
         reg_en_q <= reg_en_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
      end
   end

   tmr_sat_counter #(.W(ERRW)) u_err_cnt (
      .CP  (CP),
      .CDN (CDN),
      .clr (err_clr),
      .inc (inc),
      .cnt (err_cnt)
   );

   assign wr_ready   = (state_q == IDLE);
   assign reg_en     = reg_en_q;
   assign reg_d      = data_q;
   assign done_pulse = done_q;
   assign fail_pulse = fail_q;

endmodule

// File: tb/tb_tmr_cfg_write_verify.sv
// tb_tmr_cfg_write_verify: directed write/verify scenarios against a behavioural bank
// model with injectable one-shot bit flip (row 7) and stuck-at-zero row faults.
module tb_tmr_cfg_write_verify;

   localparam int NREG = 16;
   localparam int DW   = 16;
   localparam int AW   = 5;

   logic               CP = 1'b0;
   logic               CDN = 1'b0;
   logic               wr_valid = 1'b0;
   logic               wr_ready;
   logic [AW-1:0]      wr_addr = '0;
   logic [DW-1:0]      wr_data = '0;
   logic [NREG-1:0]    reg_en;
   logic [DW-1:0]      reg_d;
   logic [NREG*DW-1:0] reg_q;
   logic               done_pulse;
   logic               fail_pulse;
   logic [7:0]         err_cnt;
   logic               err_clr = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   logic [DW-1:0] bank [NREG];
   int            w7 = 0;
   logic          flip_en = 1'b0;
   int            stuck_row = -1;

   logic [NREG-1:0] en_log   [1:16];
   logic            done_log [1:16];
   logic            fail_log [1:16];
   logic            rdy_log  [1:16];
   int              en_pulses, dones, fails, not_rdy;

   tmr_cfg_write_verify #(.NREG(NREG), .DW(DW), .AW(AW), .MAX_RETRY(2), .ERRW(8)) dut (
      .CP         (CP),
      .CDN        (CDN),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .reg_en     (reg_en),
      .reg_d      (reg_d),
      .reg_q      (reg_q),
      .done_pulse (done_pulse),
      .fail_pulse (fail_pulse),
      .err_cnt    (err_cnt),
      .err_clr    (err_clr)
   );

   always #5 CP = ~CP;

   always_ff @(posedge CP or negedge CDN)
      if (!CDN) for (int i = 0; i < NREG; i++) bank[i] <= '0;
      else      for (int i = 0; i < NREG; i++) if (reg_en[i]) bank[i] <= reg_d;

   always @(posedge CP) if (reg_en[7]) w7 <= w7 + 1;

   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NREG; i++) begin
         reg_q[i*DW +: DW] = (i == stuck_row) ? '0 : bank[i];
         if (i == 7 && flip_en && w7 < 2) reg_q[i*DW +: DW] = bank[i] ^ 16'h0001;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   // Transfer at edge t0, then log outputs for cycles t0+1..t0+n
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
      wr_addr = a;
      wr_data = d;
      wr_valid = 1'b1;
      rdy_log[1] = wr_ready;
      step();
      wr_valid = 1'b0;
      en_pulses = 0; dones = 0; fails = 0; not_rdy = 0;
      for (int c = 1; c <= n; c++) begin
         en_log[c] = reg_en;
         done_log[c] = done_pulse;
         fail_log[c] = fail_pulse;
         rdy_log[c] = wr_ready;
         if (reg_en != '0) en_pulses++;
         if (done_pulse) dones++;
         if (fail_pulse) fails++;
         if (!wr_ready) not_rdy++;
         step();
      end
   endtask

   initial begin
      repeat (2) step();
      check("rst_ready", wr_ready, 1);
      check("rst_en", reg_en, 0);
      check("rst_d", reg_d, 0);
      check("rst_pulses", {done_pulse, fail_pulse}, 0);
      check("rst_err", err_cnt, 0);
      CDN = 1'b1;
      step();

      do_write(3, 16'hA5C3, 5);
      check("t1_en_t1", en_log[1], 16'h0008);
      check("t1_en_count", en_pulses, 1);
      check("t1_ready_t1", rdy_log[1], 0);
      check("t1_done_t4", done_log[4], 1);
      check("t1_done_count", dones, 1);
      check("t1_ready_t4", rdy_log[4], 1);
      check("t1_reg_d", reg_d, 16'hA5C3);
      check("t1_err", err_cnt, 0);

      flip_en = 1'b1;
      do_write(7, 16'h1234, 8);
      check("t2_en_t1", en_log[1], 16'h0080);
      check("t2_en_t4", en_log[4], 16'h0080);
      check("t2_en_count", en_pulses, 2);
      check("t2_done_t7", done_log[7], 1);
      check("t2_done_count", dones, 1);
      check("t2_err", err_cnt, 1);
      flip_en = 1'b0;

      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("clr_err", err_cnt, 0);

      stuck_row = 2;
      do_write(2, 16'hFFFF, 11);
      check("t3_en_count", en_pulses, 3);
      check("t3_en_t7", en_log[7], 16'h0004);
      check("t3_fail_t10", fail_log[10], 1);
      check("t3_fail_count", fails, 1);
      check("t3_done_count", dones, 0);
      check("t3_err", err_cnt, 3);

      do_write(16, 16'h5555, 3);
      check("t4_fail_t1", fail_log[1], 1);
      check("t4_fail_count", fails, 1);
      check("t4_en_count", en_pulses, 0);
      check("t4_not_ready", not_rdy, 0);
      check("t4_ready_pre", rdy_log[1], 1);
      check("t4_err", err_cnt, 3);

      for (int k = 0; k < 84; k++) do_write(2, 16'hFFFF, 10);
      check("t5_sat", err_cnt, 255);
      do_write(2, 16'hFFFF, 8);
      check("t5_hold_mid", err_cnt, 255);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t5_clr_fail", fail_pulse, 1);
      check("t5_clr_wins", err_cnt, 0);
      step();
      for (int k = 0; k < 85; k++) do_write(2, 16'hFFFF, 10);
      check("t5_resat", err_cnt, 255);
      do_write(2, 16'hFFFF, 10);
      check("t5_fail", fails, 1);
      check("t5_hold", err_cnt, 255);
      stuck_row = -1;

      wr_addr = 5;
      wr_data = 16'hC3C3;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      check("t6_write", reg_en, 16'h0020);
      step();
      CDN = 1'b0;
      #1;
      check("t6_rst_en", reg_en, 0);
      check("t6_rst_d", reg_d, 0);
      check("t6_rst_ready", wr_ready, 1);
      check("t6_rst_pulses", {done_pulse, fail_pulse}, 0);
      check("t6_rst_err", err_cnt, 0);
      step();
      CDN = 1'b1;
      en_pulses = 0; dones = 0; fails = 0;
      for (int c = 0; c < 6; c++) begin
         if (reg_en != '0) en_pulses++;
         if (done_pulse) dones++;
         if (fail_pulse) fails++;
         step();
      end
      check("t6_post_en", en_pulses, 0);
      check("t6_post_pulses", dones + fails, 0);
      do_write(5, 16'h5A5A, 5);
      check("t6_next_en", en_log[1], 16'h0020);
      check("t6_next_done", done_log[4], 1);
      check("t6_next_err", err_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
